id_ex_pipe: RTL

Parametrised decode-to-execute pipeline register. It adds a valid/ready handshake, a one-entry skid buffer, flush and a bubble counter. It sits between the decode stage and the execute stage of the openMips core. It carries the decoded micro-op (PC, ALU op/select, two operands, destination register, write enable, delay-slot flag, link address) and presents a NOP when empty or flushed.

---
 rtl/id_ex_pipe.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/id_ex_pipe.sv
// Decode-to-execute pipeline register: one main stage plus a one-entry skid buffer, with flush and a bubble counter.
// Accepted micro-ops reach execute one cycle later. A stall holds ex_* stable and id_ready drops once the skid entry fills.
module id_ex_pipe #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ALUOP_W   = 8,
    parameter int ALUSEL_W  = 3,
    parameter int REGADDR_W = 5,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 id_valid,
    output logic                 id_ready,
    input  logic [ADDR_W-1:0]    id_pc,
    input  logic [ADDR_W-1:0]    id_link_addr,
    input  logic [ALUOP_W-1:0]   id_aluop,
    input  logic [ALUSEL_W-1:0]  id_alusel,
    input  logic [DATA_W-1:0]    id_rdata1,
    input  logic [DATA_W-1:0]    id_rdata2,
    input  logic [REGADDR_W-1:0] id_rw,
    input  logic                 id_wreg,
    input  logic                 id_delayslot,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [ADDR_W-1:0]    ex_pc,
    output logic [ADDR_W-1:0]    ex_link_addr,
    output logic [ALUOP_W-1:0]   ex_aluop,
    output logic [ALUSEL_W-1:0]  ex_alusel,
    output logic [DATA_W-1:0]    ex_rdata1,
    output logic [DATA_W-1:0]    ex_rdata2,
    output logic [REGADDR_W-1:0] ex_rw,
    output logic                 ex_wreg,
    output logic                 ex_delayslot,
    output logic [CNT_W-1:0]     bubble_cnt
);

    typedef struct packed {
        logic [ADDR_W-1:0]    pc;
        logic [ALUOP_W-1:0]   aluop;
        logic [ALUSEL_W-1:0]  alusel;
        logic [DATA_W-1:0]    rdata1;
        logic [DATA_W-1:0]    rdata2;
        logic [REGADDR_W-1:0] rw;
        logic                 wreg;
        logic                 delayslot;
        logic [ADDR_W-1:0]    link_addr;
    } uop_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    uop_t             m_q, m_nxt;
    uop_t             s_q, s_nxt;
    uop_t             in_uop;
    logic             in_fire;
    logic             out_fire;
    logic [CNT_W-1:0] cnt_q;

    assign in_uop = '{
        pc:        id_pc,
        aluop:     id_aluop,
        alusel:    id_alusel,
        rdata1:    id_rdata1,
        rdata2:    id_rdata2,
        rw:        id_rw,
        wreg:      id_wreg,
        delayslot: id_delayslot,
        link_addr: id_link_addr
    };

    // Ready depends only on the state register, so execute stalls never ripple combinationally upstream.
    assign id_ready = (state != FULL) && !rst;
    assign ex_valid = (state != EMPTY);
    assign in_fire  = id_valid && id_ready;
    assign out_fire = ex_valid && ex_ready;

    always_comb begin
        state_nxt = state;
        m_nxt     = m_q;
        s_nxt     = s_q;
        if (flush) begin
            state_nxt = EMPTY;
            m_nxt     = '0;
            s_nxt     = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt = ONE;
                        m_nxt     = in_uop;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        m_nxt = in_uop;
                    end else if (in_fire) begin
                        state_nxt = FULL;
                        s_nxt     = in_uop;
                    end else if (out_fire) begin
                        // Main register is zeroed on drain so ex_* shows the NOP payload while empty.
                        state_nxt = EMPTY;
                        m_nxt     = '0;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_nxt = ONE;
                        m_nxt     = s_q;
                        s_nxt     = '0;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    m_nxt     = '0;
                    s_nxt     = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            m_q   <= '0;
            s_q   <= '0;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            m_q   <= m_nxt;
            s_q   <= s_nxt;
            if (!ex_valid && ex_ready && !flush && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign ex_pc        = m_q.pc;
    assign ex_link_addr = m_q.link_addr;
    assign ex_aluop     = m_q.aluop;
    assign ex_alusel    = m_q.alusel;
    assign ex_rdata1    = m_q.rdata1;
    assign ex_rdata2    = m_q.rdata2;
    assign ex_rw        = m_q.rw;
    assign ex_wreg      = m_q.wreg;
    assign ex_delayslot = m_q.delayslot;
    assign bubble_cnt   = cnt_q;

endmodule
